byte_unstriping: RTL and testbench

Receive-side counterpart of the 4-lane transmit striper. It accepts one 4-byte group (lane0..lane3) per group strobe and re-serialises it into a 1-byte-per-clock stream in lane order 0,1,2,3. A one-group pending slot absorbs early-arriving groups, and a sticky error flags lost groups. It sits downstream of lane deskew/sync and feeds the receive data path.

---
 rtl/byte_unstriping_pkg.sv | 12 +
 rtl/byte_unstriping_group_reg.sv | 22 ++
 rtl/byte_unstriping.sv | 130 +++++++++++++
 tb/tb_byte_unstriping.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/byte_unstriping_pkg.sv
// Shared definitions for the 4-lane byte striper/unstriper pair.
package byte_unstriping_pkg;

  localparam int unsigned LANES = 4;
  localparam logic [7:0] INACTIVE_BYTE = 8'h00;

  typedef enum logic {
    IDLE = 1'b0,
    SER  = 1'b1
  } state_t;

endpackage

// File: rtl/byte_unstriping_group_reg.sv
// One 4-lane group holding register with load enable and synchronous clear.
module group_reg
  import byte_unstriping_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [LANES-1:0][DATA_W-1:0]  d,
  output logic [LANES-1:0][DATA_W-1:0]  q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/byte_unstriping.sv
// Re-serialises 4-byte lane groups into a byte stream, lane 0 first, with a
// one-group pending slot and a sticky overflow flag for dropped groups.
module byte_unstriping
  import byte_unstriping_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter logic [DATA_W-1:0] INACTIVE = DATA_W'(INACTIVE_BYTE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic [DATA_W-1:0] rx_lane0,
  input  logic [DATA_W-1:0] rx_lane1,
  input  logic [DATA_W-1:0] rx_lane2,
  input  logic [DATA_W-1:0] rx_lane3,
  input  logic              lanes_valid,
  output logic [DATA_W-1:0] rx_Data,
  output logic              rx_Valid,
  output logic              busy,
  output logic              overflow
);

  state_t state, state_n;
  logic [1:0]              idx, idx_n;
  logic [DATA_W-1:0]       data_n;
  logic                    valid_n;
  logic                    ovf_n;
  logic                    pend_full, pend_full_n;
  logic                    act_load, pend_load;
  logic [LANES-1:0][DATA_W-1:0] in_group, act_d, active_q, pend_q;

  assign in_group = {rx_lane3, rx_lane2, rx_lane1, rx_lane0};
  assign busy     = (state == SER);

  group_reg #(.DATA_W(DATA_W)) u_active (
    .clk  (clk),
    .rst  (rst),
    .load (act_load & enb),
    .d    (act_d),
    .q    (active_q)
  );

  group_reg #(.DATA_W(DATA_W)) u_pending (
    .clk  (clk),
    .rst  (rst),
    .load (pend_load & enb),
    .d    (in_group),
    .q    (pend_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      rx_Data   <= INACTIVE;
      rx_Valid  <= 1'b0;
      overflow  <= 1'b0;
      pend_full <= 1'b0;
    end else if (enb) begin
      state     <= state_n;
      idx       <= idx_n;
      rx_Data   <= data_n;
      rx_Valid  <= valid_n;
      overflow  <= ovf_n;
      pend_full <= pend_full_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    data_n      = rx_Data;
    valid_n     = rx_Valid;
    ovf_n       = overflow;
    pend_full_n = pend_full;
    act_load    = 1'b0;
    pend_load   = 1'b0;
    act_d       = in_group;

    unique case (state)
      IDLE: begin
        if (lanes_valid) begin
          act_load = 1'b1;
          data_n   = rx_lane0;
          valid_n  = 1'b1;
          idx_n    = '0;
          state_n  = SER;
        end else begin
          data_n  = INACTIVE;
          valid_n = 1'b0;
        end
      end
      SER: begin
        if (idx != 2'd3) begin
          data_n = active_q[idx + 2'd1];
          idx_n  = idx + 2'd1;
          if (lanes_valid) begin
            if (!pend_full) begin
              pend_load   = 1'b1;
              pend_full_n = 1'b1;
            end else begin
              ovf_n = 1'b1;
            end
          end
        end else if (pend_full) begin
          // Pending group goes out first; a simultaneous strobe refills the slot.
          act_load = 1'b1;
          act_d    = pend_q;
          data_n   = pend_q[0];
          idx_n    = '0;
          if (lanes_valid) begin
            pend_load = 1'b1;
          end else begin
            pend_full_n = 1'b0;
          end
        end else if (lanes_valid) begin
          act_load = 1'b1;
          data_n   = rx_lane0;
          idx_n    = '0;
        end else begin
          data_n  = INACTIVE;
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_byte_unstriping.sv
// Scoreboard bench: accepted groups are queued as expected bytes and popped
// by a monitor whenever the unstriper emits a valid byte.
module tb_byte_unstriping;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b1;
  logic [7:0] rx_lane0 = '0, rx_lane1 = '0, rx_lane2 = '0, rx_lane3 = '0;
  logic       lanes_valid = 1'b0;
  logic [7:0] rx_Data;
  logic       rx_Valid, busy, overflow;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  logic [7:0] prev_data;
  logic       prev_valid;

  always #5 clk = ~clk;

  byte_unstriping #(.DATA_W(8), .INACTIVE(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .rx_lane0    (rx_lane0),
    .rx_lane1    (rx_lane1),
    .rx_lane2    (rx_lane2),
    .rx_lane3    (rx_lane3),
    .lanes_valid (lanes_valid),
    .rx_Data     (rx_Data),
    .rx_Valid    (rx_Valid),
    .busy        (busy),
    .overflow    (overflow)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: rst/enb seen here are the values the preceding posedge sampled.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_valid", {7'd0, rx_Valid}, 8'd0);
        check("reset_data", rx_Data, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'd0);
        check("reset_ovf", {7'd0, overflow}, 8'd0);
      end else if (!enb) begin
        check("stall_data", rx_Data, prev_data);
        check("stall_valid", {7'd0, rx_Valid}, {7'd0, prev_valid});
      end else begin
        check("valid", {7'd0, rx_Valid}, {7'd0, exp_q.size() > 0});
        if (rx_Valid && exp_q.size() > 0) begin
          check("data", rx_Data, exp_q.pop_front());
        end else if (!rx_Valid) begin
          check("idle_data", rx_Data, 8'h00);
        end
        check("busy", {7'd0, busy}, {7'd0, rx_Valid});
      end
      check("overflow", {7'd0, overflow}, {7'd0, exp_ovf});
      prev_data  = rx_Data;
      prev_valid = rx_Valid;
    end
  end

  // Drives one cycle; an enabled strobe is kept only if at most one group's
  // worth of bytes is still waiting to appear (current group tail + one slot).
  task automatic step(input logic r, input logic e, input logic v, input logic [31:0] g);
    @(negedge clk);
    #1;
    rst         = r;
    enb         = e;
    lanes_valid = v;
    {rx_lane3, rx_lane2, rx_lane1, rx_lane0} = g;
    if (r) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else if (e && v) begin
      if (exp_q.size() <= 4) begin
        exp_q.push_back(g[7:0]);
        exp_q.push_back(g[15:8]);
        exp_q.push_back(g[23:16]);
        exp_q.push_back(g[31:24]);
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    // single group
    step(1'b0, 1'b1, 1'b1, 32'h44332211);
    idle(6);
    // back-to-back, strobes every 4 cycles
    step(1'b0, 1'b1, 1'b1, 32'hADACABAA);
    idle(3);
    step(1'b0, 1'b1, 1'b1, 32'hB3B2B1B0);
    idle(6);
    // early arrival into pending slot
    step(1'b0, 1'b1, 1'b1, 32'hA3A2A1A0);
    step(1'b0, 1'b1, 1'b1, 32'hB3B2B1B0);
    idle(9);
    // overflow: third group dropped, flag sticky until reset
    step(1'b0, 1'b1, 1'b1, 32'hA3A2A1A0);
    step(1'b0, 1'b1, 1'b1, 32'hB3B2B1B0);
    step(1'b0, 1'b1, 1'b1, 32'hC3C2C1C0);
    idle(10);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    // enb stall with an ignored strobe
    step(1'b0, 1'b1, 1'b1, 32'h3C2B1A09);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    idle(6);
    // reset mid-group, then a clean group
    step(1'b0, 1'b1, 1'b1, 32'h77665544);
    step(1'b0, 1'b1, 1'b1, 32'h8899AABB);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h13121110);
    idle(6);
    // randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 3) == 0), $urandom);
    end
    idle(12);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d bytes never appeared, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
